// File: rtl/cpu_mode_pkg.sv
// Shared types and the mode decode table for the CPU mode sequencer.
// The decode is stored as {enable mask, boot select} constant arrays indexed by mode.
package cpu_mode_pkg;

   typedef enum logic [1:0] {
      SINGLE = 2'b00,
      DMR    = 2'b01,
      TMR    = 2'b10,
      MULTI  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_SLEEP = 3'd1,
      HOLD_RST   = 3'd2,
      RELEASE    = 3'd3,
      DONE       = 3'd4
   } state_e;

   // Bit n belongs to hart n; hart 0 is the only one running out of reset.
   localparam logic [2:0] MODE_EN  [4] = '{3'b001, 3'b011, 3'b111, 3'b111};
   localparam logic [2:0] MODE_SEL [4] = '{3'b000, 3'b000, 3'b000, 3'b110};

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/cpu_mode_cnt.sv
// Saturating up-counter with synchronous clear; last_o flags the final counted cycle.
// last_o is decoded from the count only, so callers combine it with their own enable.
module cpu_mode_cnt
   import cpu_mode_pkg::*;
#(
   parameter int unsigned MAX = 1,
   parameter int unsigned W   = cnt_width(MAX)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic clr_i,
   output logic last_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != W'(MAX))) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/cpu_mode_sequencer.sv
// Moves the three-hart CPU subsystem between execution modes: wait for WFI sleep,
// hold harts in reset, then release all enabled harts together with the new boot select.
module cpu_mode_sequencer
   import cpu_mode_pkg::*;
#(
   parameter int unsigned NHARTS         = 3,
   parameter int unsigned RST_CYCLES     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [NHARTS-1:0] sleep_i,
   output logic [NHARTS-1:0] core_rst_no,
   output logic [NHARTS-1:0] boot_sel_o,
   output logic [1:0]        mode_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o
);

   localparam bit          TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam int unsigned TO_MAX = TO_EN ? TIMEOUT_CYCLES : 1;
   localparam int unsigned RS_MAX = (RST_CYCLES < 1) ? 1 : RST_CYCLES;

   state_e            state_q, state_d;
   mode_e             target_q, target_d;
   mode_e             mode_q, mode_d;
   logic [NHARTS-1:0] core_rst_q, core_rst_d;
   logic [NHARTS-1:0] boot_sel_q, boot_sel_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;

   logic wait_en, wait_last;
   logic hold_en, hold_last;
   logic all_asleep;

   cpu_mode_cnt #(.MAX(TO_MAX)) u_wait_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (wait_en),
      .clr_i  (state_q != WAIT_SLEEP),
      .last_o (wait_last)
   );

   cpu_mode_cnt #(.MAX(RS_MAX)) u_hold_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (hold_en),
      .clr_i  (state_q != HOLD_RST),
      .last_o (hold_last)
   );

   // Harts already held in reset never report sleep, so they are masked out.
   assign all_asleep = ((sleep_i & core_rst_q) == core_rst_q);

   // Output registers load from the next state, so each output changes on the
   // same edge that enters the state it belongs to.
   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      mode_d     = mode_q;
      core_rst_d = core_rst_q;
      boot_sel_d = boot_sel_q;
      timeout_d  = timeout_q;
      wait_en    = 1'b0;
      hold_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               target_d  = mode_e'(mode_i);
               timeout_d = 1'b0;
               state_d   = WAIT_SLEEP;
            end
         end
         WAIT_SLEEP: begin
            if (all_asleep) begin
               state_d    = HOLD_RST;
               core_rst_d = '0;
               boot_sel_d = NHARTS'(MODE_SEL[target_q]);
            end else begin
               wait_en = 1'b1;
               if (TO_EN && wait_last) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         HOLD_RST: begin
            hold_en    = 1'b1;
            core_rst_d = '0;
            if (hold_last) begin
               state_d    = RELEASE;
               core_rst_d = NHARTS'(MODE_EN[target_q]);
               mode_d     = target_q;
            end
         end
         RELEASE: state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         target_q   <= SINGLE;
         mode_q     <= SINGLE;
         core_rst_q <= NHARTS'(1);
         boot_sel_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         mode_q     <= mode_d;
         core_rst_q <= core_rst_d;
         boot_sel_q <= boot_sel_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   assign core_rst_no = core_rst_q;
   assign boot_sel_o  = boot_sel_q;
   assign mode_o      = mode_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cpu_mode_sequencer.sv
// Bench for cpu_mode_sequencer: a default instance plus a short-timeout instance.
// Expected {mode, enable mask, boot select} is queued at each start and checked at done_o.
module tb_cpu_mode_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [2:0] sleep = 3'b000;
   logic [2:0] core_rst, boot_sel;
   logic [1:0] m_o;
   logic       busy, done, timeout;

   logic       start_t = 1'b0;
   logic [1:0] mode_t = 2'b00;
   logic [2:0] sleep_t = 3'b000;
   logic [2:0] core_rst_t, boot_sel_t;
   logic [1:0] m_o_t;
   logic       busy_t, done_t, timeout_t;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];

   cpu_mode_sequencer #(.NHARTS(3), .RST_CYCLES(8), .TIMEOUT_CYCLES(1024)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .sleep_i(sleep),
      .core_rst_no(core_rst), .boot_sel_o(boot_sel), .mode_o(m_o),
      .busy_o(busy), .done_o(done), .timeout_o(timeout)
   );

   cpu_mode_sequencer #(.NHARTS(3), .RST_CYCLES(8), .TIMEOUT_CYCLES(16)) dut_t (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_t), .mode_i(mode_t), .sleep_i(sleep_t),
      .core_rst_no(core_rst_t), .boot_sel_o(boot_sel_t), .mode_o(m_o_t),
      .busy_o(busy_t), .done_o(done_t), .timeout_o(timeout_t)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic [1:0] m);
      start = 1'b1;
      mode  = m;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (10) step();
      total++;
      if ({core_rst, boot_sel, m_o, busy, done, timeout} !== 11'b001_000_00_0_0_0) begin
         bad++;
         $display("FAIL reset_main: got %b required %b",
                  {core_rst, boot_sel, m_o, busy, done, timeout}, 11'b001_000_00_0_0_0);
      end
      total++;
      if ({core_rst_t, boot_sel_t, m_o_t, busy_t, done_t, timeout_t} !== 11'b001_000_00_0_0_0) begin
         bad++;
         $display("FAIL reset_timeout_inst: got %b required %b",
                  {core_rst_t, boot_sel_t, m_o_t, busy_t, done_t, timeout_t}, 11'b001_000_00_0_0_0);
      end
   endtask

   task automatic test_tmr();
      logic [7:0] e;
      sleep = 3'b001;
      exp_q.push_back({2'b10, 3'b111, 3'b000});
      drive_start(2'b10);
      total++;
      if (busy !== 1'b1 || core_rst !== 3'b001) begin
         bad++;
         $display("FAIL tmr_wait_c1: got busy=%b rst=%b required busy=1 rst=001", busy, core_rst);
      end
      for (int c = 2; c <= 9; c++) begin
         step();
         total++;
         if (core_rst !== 3'b000 || done !== 1'b0) begin
            bad++;
            $display("FAIL tmr_hold_c%0d: got rst=%b done=%b required rst=000 done=0", c, core_rst, done);
         end
      end
      step();
      total++;
      if (core_rst !== 3'b111 || m_o !== 2'b10 || done !== 1'b0) begin
         bad++;
         $display("FAIL tmr_release_c10: got rst=%b mode=%b done=%b required 111 10 0", core_rst, m_o, done);
      end
      step();
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL tmr_done_c11: got done=%b required 1", done);
      end
      e = exp_q.pop_front();
      total++;
      if ({m_o, core_rst, boot_sel} !== e) begin
         bad++;
         $display("FAIL tmr_result: got %b required %b", {m_o, core_rst, boot_sel}, e);
      end
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL tmr_idle_c12: got done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic test_multi_wait();
      logic [7:0] e;
      int stuck_bad = 0;
      int n = 0;
      sleep = 3'b011;
      exp_q.push_back({2'b11, 3'b111, 3'b110});
      drive_start(2'b11);
      for (int c = 0; c < 50; c++) begin
         step();
         if (busy !== 1'b1 || core_rst !== 3'b111 || done !== 1'b0) stuck_bad++;
      end
      total++;
      if (stuck_bad != 0) begin
         bad++;
         $display("FAIL multi_wait_sleep: got %0d cycles leaving wait early required 0", stuck_bad);
      end
      sleep = 3'b111;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL multi_done: got done=%b after %0d cycles required 1", done, n);
      end
      e = exp_q.pop_front();
      total++;
      if ({m_o, core_rst, boot_sel} !== e || timeout !== 1'b0) begin
         bad++;
         $display("FAIL multi_result: got %b to=%b required %b to=0", {m_o, core_rst, boot_sel}, timeout, e);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] e;
      int done_seen = 0;
      int n = 0;
      sleep_t = 3'b000;
      mode_t  = 2'b01;
      start_t = 1'b1;
      step();
      start_t = 1'b0;
      for (int c = 2; c <= 16; c++) begin
         step();
         if (done_t === 1'b1) done_seen++;
      end
      total++;
      if (busy_t !== 1'b1 || timeout_t !== 1'b0) begin
         bad++;
         $display("FAIL timeout_early_c16: got busy=%b to=%b required 1 0", busy_t, timeout_t);
      end
      step();
      total++;
      if ({timeout_t, busy_t, core_rst_t, boot_sel_t, m_o_t} !== 10'b1_0_001_000_00) begin
         bad++;
         $display("FAIL timeout_c17: got %b required %b",
                  {timeout_t, busy_t, core_rst_t, boot_sel_t, m_o_t}, 10'b1_0_001_000_00);
      end
      repeat (5) begin
         step();
         if (done_t === 1'b1) done_seen++;
      end
      total++;
      if (timeout_t !== 1'b1 || done_seen != 0) begin
         bad++;
         $display("FAIL timeout_sticky: got to=%b done_pulses=%0d required to=1 done_pulses=0", timeout_t, done_seen);
      end
      sleep_t = 3'b001;
      exp_q.push_back({2'b01, 3'b011, 3'b000});
      start_t = 1'b1;
      step();
      start_t = 1'b0;
      total++;
      if (timeout_t !== 1'b0 || busy_t !== 1'b1) begin
         bad++;
         $display("FAIL timeout_clear: got to=%b busy=%b required 0 1", timeout_t, busy_t);
      end
      while (done_t !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      e = exp_q.pop_front();
      total++;
      if (done_t !== 1'b1 || {m_o_t, core_rst_t, boot_sel_t} !== e) begin
         bad++;
         $display("FAIL timeout_rerun: got done=%b %b required done=1 %b", done_t, {m_o_t, core_rst_t, boot_sel_t}, e);
      end
   endtask

   task automatic test_ignore_start();
      logic [7:0] e;
      int busy_cnt = 0;
      int n = 0;
      sleep = 3'b111;
      exp_q.push_back({2'b00, 3'b001, 3'b000});
      drive_start(2'b00);
      step();
      total++;
      if (core_rst !== 3'b000 || boot_sel !== 3'b000) begin
         bad++;
         $display("FAIL ignore_hold_entry: got rst=%b sel=%b required 000 000", core_rst, boot_sel);
      end
      start = 1'b1;
      mode  = 2'b10;
      repeat (3) step();
      start = 1'b0;
      mode  = 2'b00;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      e = exp_q.pop_front();
      total++;
      if (done !== 1'b1 || {m_o, core_rst, boot_sel} !== e) begin
         bad++;
         $display("FAIL ignore_result: got done=%b %b required done=1 %b", done, {m_o, core_rst, boot_sel}, e);
      end
      repeat (6) begin
         step();
         if (busy === 1'b1) busy_cnt++;
      end
      total++;
      if (busy_cnt != 0) begin
         bad++;
         $display("FAIL ignore_no_queue: got %0d busy cycles required 0", busy_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      int n = 1;
      sleep = 3'b001;
      drive_start(2'b11);
      step();
      step();
      total++;
      if (boot_sel !== 3'b110 || core_rst !== 3'b000) begin
         bad++;
         $display("FAIL midrst_hold: got sel=%b rst=%b required 110 000", boot_sel, core_rst);
      end
      #2;
      rst_n = 1'b0;
      #2;
      total++;
      if ({core_rst, boot_sel, m_o, busy, done, timeout} !== 11'b001_000_00_0_0_0) begin
         bad++;
         $display("FAIL midrst_async: got %b required %b",
                  {core_rst, boot_sel, m_o, busy, done, timeout}, 11'b001_000_00_0_0_0);
      end
      step();
      rst_n = 1'b1;
      step();
      exp_q.push_back({2'b10, 3'b111, 3'b000});
      drive_start(2'b10);
      while (done !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      total++;
      if (n != 11) begin
         bad++;
         $display("FAIL midrst_latency: got done at cycle %0d required 11", n);
      end
      e = exp_q.pop_front();
      total++;
      if ({m_o, core_rst, boot_sel} !== e) begin
         bad++;
         $display("FAIL midrst_result: got %b required %b", {m_o, core_rst, boot_sel}, e);
      end
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_tmr();
      test_multi_wait();
      test_timeout();
      test_ignore_start();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_mode_sequencer.md
Name: cpu_mode_sequencer

Overview:
Sequences the three-hart external CPU subsystem between execution modes (single, DMR, TMR, multicore).
Drives each hart's active-low core-reset enable and boot-address select, i.e. the per-core Reset_core_FSM / Select_boot_addr controls of the CPU system.
Accepts a mode-change request, waits for the currently running harts to reach WFI sleep, holds the harts in reset for a programmed time, then releases them with the new boot selection.
Sits between the mode control register and the CPU system.

Parameters:
NHARTS, 3, number of harts controlled (decode table defined for 3).
RST_CYCLES, 8, cycles the harts are held in reset during a switch (>=1).
TIMEOUT_CYCLES, 1024, max cycles to wait for sleep; 0 disables the timeout.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
start_i  in  1  mode-change request; sampled only in IDLE.
mode_i  in  2  target mode: 00 SINGLE, 01 DMR, 10 TMR, 11 MULTI.
sleep_i  in  NHARTS  per-hart core_sleep from the CPU system.
core_rst_no  out  NHARTS  per-hart reset enable; 0 = held in reset, 1 = running (ANDed with rst_ni downstream).
boot_sel_o  out  NHARTS  per-hart boot select; 0 = base boot address, 1 = WFI boot address.
mode_o  out  2  currently applied mode.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle pulse when a switch completes.
timeout_o  out  1  sticky error flag; cleared by the next accepted start_i.

Behaviour:
- Reset values: state IDLE, mode_o=00, core_rst_no=001, boot_sel_o=000, busy_o=0, done_o=0, timeout_o=0, counters=0.
- Mode decode, as {enable mask, boot select}:
  - SINGLE: en=001, sel=000.
  - DMR: en=011, sel=000.
  - TMR: en=111, sel=000.
  - MULTI: en=111, sel=110.
- FSM states: IDLE, WAIT_SLEEP, HOLD_RST, RELEASE, DONE.
- IDLE:
  - start_i=1 latches mode_i into target_q and clears timeout_o.
  - Next state is WAIT_SLEEP; busy_o rises on the next cycle.
- WAIT_SLEEP:
  - Condition: (sleep_i & core_rst_no) == core_rst_no, i.e. every running hart is asleep; harts held in reset are ignored.
  - When the condition holds, go to HOLD_RST.
  - Otherwise increment the wait counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, set timeout_o and return to IDLE.
  - On timeout, core_rst_no, boot_sel_o and mode_o are unchanged and done_o is not pulsed.
- HOLD_RST:
  - core_rst_no=000 from the first HOLD_RST cycle.
  - boot_sel_o is updated to the target value on HOLD_RST entry, so it is stable before release.
  - The reset counter runs; after exactly RST_CYCLES cycles in HOLD_RST, go to RELEASE.
- RELEASE:
  - For one cycle, core_rst_no = target enable mask, mode_o = target_q.
  - All enabled harts leave reset on the same edge (lockstep requirement).
  - Next state is DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Latency with harts already asleep: start_i at cycle 0 gives WAIT_SLEEP at 1, HOLD_RST at 2..(1+RST_CYCLES), RELEASE at 2+RST_CYCLES, done_o at 3+RST_CYCLES.
- start_i while busy_o=1 is ignored. No queuing.
- start_i with mode_i equal to mode_o still runs the full sequence (used as a re-sync).
- A sleep_i deassertion after the condition has been met is ignored once in HOLD_RST.
- Asynchronous reset mid-sequence returns all outputs to the reset values immediately.
- Counter widths: $clog2(RST_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1) (minimum 1 bit). Counters saturate and never wrap.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package cpu_mode_pkg holds:
  - typedef enum logic [1:0] mode_e {SINGLE, DMR, TMR, MULTI};
  - typedef enum for the FSM state;
  - constant arrays MODE_EN[4] and MODE_SEL[4] (3-bit each) implementing the decode table.
- Sub-module: none beyond one reusable up-counter, cpu_mode_cnt (enable, clear, terminal-count compare, saturating). It is instantiated twice, for wait and hold.

Test Plan:
- Reset, then idle 10 cycles: core_rst_no=001, boot_sel_o=000, mode_o=00, busy_o=0.
- sleep_i=001, start_i with mode=10 (TMR), RST_CYCLES=8:
  - core_rst_no=000 for cycles 2..9;
  - 111 from cycle 10;
  - done_o pulse at cycle 11;
  - mode_o=10.
- From TMR, sleep_i=011 (hart 2 awake), start mode=11:
  - stays in WAIT_SLEEP;
  - sleep_i[2] rises 50 cycles later, then the sequence completes;
  - boot_sel_o=110, core_rst_no=111.
- TIMEOUT_CYCLES=16, hart never sleeps:
  - timeout_o=1 after 16 wait cycles;
  - outputs unchanged; no done_o;
  - next accepted start_i clears timeout_o.
- start_i pulses during HOLD_RST: ignored, and target_q is unchanged.
- rst_ni asserted during HOLD_RST: outputs return to the reset values asynchronously, and the next start_i runs a clean sequence.
